// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctrl_pkg
//  Purpose  : Shared FSM state encoding and default sizing constants for the
//             interrupt controller.
//  Revision : 1.0  initial release
// ============================================================================
package int_ctrl_pkg;

    localparam int c_DEFAULT_NUM_CH = 4;
    localparam int c_DEFAULT_DATA_W = 16;

    // Controller states: waiting, offering an interrupt, handler in service
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : int_prio_enc
//  Purpose  : Combinational fixed-priority encoder; the highest set index wins.
//  Revision : 1.0  initial release
// ============================================================================
module int_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic              o_valid,
    output logic [ID_W-1:0]   o_idx
);

    // Ascending scan so the last (highest) set bit overrides lower ones
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
//  Module   : int_controller
//  Purpose  : Edge-triggered, maskable, fixed-priority interrupt controller
//             with per-channel handler vectors and a non-nesting
//             offer/acknowledge/return handshake.
//  Revision : 1.0  initial release
// ============================================================================
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int NUM_CH = c_DEFAULT_NUM_CH,
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] intReq,
    input  logic              intWrite,
    input  logic [ID_W-1:0]   intSel,
    input  logic              intMaskWrite,
    input  logic [DATA_W-1:0] intDataIn,
    input  logic              intAck,
    input  logic              intRet,
    output logic              intr,
    output logic [ID_W-1:0]   intId,
    output logic [DATA_W-1:0] intDataOut,
    output logic              intActive
);

    state_t            r_state;
    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_mask;
    logic [DATA_W-1:0] r_handler [NUM_CH];
    logic [ID_W-1:0]   r_intId;
    logic              r_intr;
    logic              r_intActive;

    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_eligible;
    logic [NUM_CH-1:0] w_ackClr;
    logic              w_winValid;
    logic [ID_W-1:0]   w_winIdx;
    logic              w_offerMasked;

    assign w_rise        = intReq & ~r_prev;
    assign w_eligible    = r_pending & r_mask;
    assign w_offerMasked = ~r_mask[r_intId];

    int_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_prioEnc (
        .i_req   (w_eligible),
        .o_valid (w_winValid),
        .o_idx   (w_winIdx)
    );

    // One-hot clear of the offered channel when the CPU accepts it
    always_comb begin
        w_ackClr = '0;
        if (r_state == REQ && intAck && !w_offerMasked) begin
            w_ackClr[r_intId] = 1'b1;
        end
    end

    // Edge detect, pending latch (a new edge beats the ack clear) and mask.
    // During reset prev tracks the live inputs so a line held high through
    // reset is not mistaken for a fresh rising edge afterwards.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_prev    <= intReq;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_prev    <= intReq;
            r_pending <= (r_pending & ~w_ackClr) | w_rise;
            if (intMaskWrite) begin
                r_mask <= intDataIn[NUM_CH-1:0];
            end
        end
    end

    // Handler vector register file
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_handler[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (intWrite && intSel == ID_W'(i)) begin
                    r_handler[i] <= intDataIn;
                end
            end
        end
    end

    // Offer/acknowledge/return state machine with registered outputs.
    // A masked-out offer is withdrawn even if an ack arrives on that edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_intId     <= '0;
            r_intr      <= 1'b0;
            r_intActive <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_winValid) begin
                        r_state <= REQ;
                        r_intId <= w_winIdx;
                        r_intr  <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_offerMasked) begin
                        r_state <= IDLE;
                        r_intr  <= 1'b0;
                    end else if (intAck) begin
                        r_state     <= SERVICE;
                        r_intr      <= 1'b0;
                        r_intActive <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (intRet) begin
                        r_state     <= IDLE;
                        r_intActive <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_intr      <= 1'b0;
                    r_intActive <= 1'b0;
                end
            endcase
        end
    end

    assign intr       = r_intr;
    assign intId      = r_intId;
    assign intActive  = r_intActive;
    assign intDataOut = (r_state == REQ || r_state == SERVICE) ? r_handler[r_intId] : '0;

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_controller
//  Purpose  : Self-checking bench for int_controller; a 4-channel/16-bit
//             instance and an 8-channel/32-bit instance share clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_int_controller;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    // 4-channel, 16-bit instance
    logic [3:0]  aReq;
    logic        aWrite;
    logic [1:0]  aSel;
    logic        aMaskWrite;
    logic [15:0] aDataIn;
    logic        aAck;
    logic        aRet;
    logic        aIntr;
    logic [1:0]  aId;
    logic [15:0] aDataOut;
    logic        aActive;

    // 8-channel, 32-bit instance
    logic [7:0]  bReq;
    logic        bWrite;
    logic [2:0]  bSel;
    logic        bMaskWrite;
    logic [31:0] bDataIn;
    logic        bAck;
    logic        bRet;
    logic        bIntr;
    logic [2:0]  bId;
    logic [31:0] bDataOut;
    logic        bActive;

    int_controller u_dutA (
        .CLK (CLK), .Reset (Reset), .intReq (aReq), .intWrite (aWrite),
        .intSel (aSel), .intMaskWrite (aMaskWrite), .intDataIn (aDataIn),
        .intAck (aAck), .intRet (aRet), .intr (aIntr), .intId (aId),
        .intDataOut (aDataOut), .intActive (aActive)
    );

    int_controller #(.NUM_CH (8), .DATA_W (32)) u_dutB (
        .CLK (CLK), .Reset (Reset), .intReq (bReq), .intWrite (bWrite),
        .intSel (bSel), .intMaskWrite (bMaskWrite), .intDataIn (bDataIn),
        .intAck (bAck), .intRet (bRet), .intr (bIntr), .intId (bId),
        .intDataOut (bDataOut), .intActive (bActive)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;
    exp_t sbQ[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sbQ.push_back(e);
    endtask

    task automatic sb_pop_check(input string tag, input logic [31:0] obsId, input logic [31:0] obsData);
        exp_t e;
        if (sbQ.size() == 0) begin
            check_val({tag, "_sbempty"}, 32'd1, 32'd0);
        end else begin
            e = sbQ.pop_front();
            check_val({tag, "_id"}, obsId, e.id);
            check_val({tag, "_data"}, obsData, e.data);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bounded wait for an offer on either instance
    task automatic wait_intr(input bit useB, input string tag);
        for (int n = 0; n < 20; n++) begin
            if ((useB ? bIntr : aIntr) === 1'b1) break;
            tick();
        end
        check_val({tag, "_seen"}, useB ? bIntr : aIntr, 32'd1);
    endtask

    task automatic a_mask(input logic [3:0] m);
        aMaskWrite = 1'b1;
        aDataIn    = {12'd0, m};
        tick();
        aMaskWrite = 1'b0;
    endtask

    task automatic a_handler(input logic [1:0] sel, input logic [15:0] d);
        aWrite  = 1'b1;
        aSel    = sel;
        aDataIn = d;
        tick();
        aWrite  = 1'b0;
    endtask

    task automatic a_ack();
        aAck = 1'b1;
        tick();
        aAck = 1'b0;
    endtask

    task automatic a_ret();
        aRet = 1'b1;
        tick();
        aRet = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        aReq = '0; aWrite = 0; aSel = '0; aMaskWrite = 0; aDataIn = '0; aAck = 0; aRet = 0;
        bReq = '0; bWrite = 0; bSel = '0; bMaskWrite = 0; bDataIn = '0; bAck = 0; bRet = 0;
        tick();
        tick();
        check_val("rst_intr", aIntr, 0);
        check_val("rst_id", aId, 0);
        check_val("rst_data", aDataOut, 0);
        check_val("rst_active", aActive, 0);
        check_val("rstB_intr", bIntr, 0);
        check_val("rstB_data", bDataOut, 0);
        Reset = 1'b0;

        // Single channel: exact latency, vector, live handler rewrite
        a_mask(4'b0010);
        a_handler(2'd1, 16'h0040);
        sb_push(1, 32'h0040);
        aReq[1] = 1'b1;
        tick();
        aReq[1] = 1'b0;
        check_val("lat_k_intr", aIntr, 0);
        tick();
        check_val("lat_k1_intr", aIntr, 1);
        sb_pop_check("single", aId, aDataOut);
        a_handler(2'd1, 16'h1234);
        check_val("wr_visible", aDataOut, 16'h1234);
        a_ack();
        check_val("ack_intr", aIntr, 0);
        check_val("ack_active", aActive, 1);
        check_val("svc_data", aDataOut, 16'h1234);
        a_ret();
        check_val("ret_active", aActive, 0);
        check_val("ret_data", aDataOut, 0);

        // Simultaneous arrivals: highest index first, then the lower one
        a_mask(4'b1111);
        for (int i = 0; i < 4; i++) a_handler(2'(i), 16'h0100 + 16'(i));
        sb_push(3, 32'h0103);
        sb_push(0, 32'h0100);
        aReq = 4'b1001;
        tick();
        aReq = '0;
        wait_intr(0, "prio_hi");
        sb_pop_check("prio_hi", aId, aDataOut);
        a_ack();
        a_ret();
        wait_intr(0, "prio_lo");
        sb_pop_check("prio_lo", aId, aDataOut);
        a_ack();
        a_ret();

        // Offer withdrawn by masking, then re-offered on unmask
        sb_push(2, 32'h0102);
        aReq[2] = 1'b1;
        tick();
        aReq[2] = 1'b0;
        wait_intr(0, "wd_offer");
        a_mask(4'b0000);
        check_val("wd_hold", aIntr, 1);
        tick();
        check_val("wd_drop", aIntr, 0);
        a_mask(4'b0100);
        check_val("wd_unmask_k", aIntr, 0);
        tick();
        check_val("wd_unmask_k1", aIntr, 1);
        sb_pop_check("wd_reoffer", aId, aDataOut);
        a_ack();
        a_ret();

        // Pending while masked, offered the cycle after the mask write
        a_mask(4'b0000);
        sb_push(2, 32'h0102);
        aReq[2] = 1'b1;
        tick();
        aReq[2] = 1'b0;
        tick();
        tick();
        check_val("masked_quiet", aIntr, 0);
        a_mask(4'b0100);
        check_val("mask_wr_k", aIntr, 0);
        tick();
        check_val("mask_wr_k1", aIntr, 1);
        sb_pop_check("mask_wr", aId, aDataOut);
        a_ack();
        a_ret();

        // Ack in IDLE is ignored
        a_ack();
        check_val("idle_ack_active", aActive, 0);
        check_val("idle_ack_intr", aIntr, 0);

        // New edge coinciding with the ack clear keeps the channel pending
        a_mask(4'b0010);
        sb_push(1, 32'h0101);
        sb_push(1, 32'h0101);
        sb_push(1, 32'h0101);
        aReq[1] = 1'b1;
        tick();
        aReq[1] = 1'b0;
        wait_intr(0, "setwin_a");
        sb_pop_check("setwin_a", aId, aDataOut);
        aAck = 1'b1;
        aReq[1] = 1'b1;
        tick();
        aAck = 1'b0;
        aReq[1] = 1'b0;
        check_val("setwin_active", aActive, 1);
        tick();
        a_ret();
        wait_intr(0, "setwin_b");
        sb_pop_check("setwin_b", aId, aDataOut);
        a_ack();
        // New edge on the same cycle as the return
        aRet = 1'b1;
        aReq[1] = 1'b1;
        tick();
        aRet = 1'b0;
        aReq[1] = 1'b0;
        check_val("retedge_active", aActive, 0);
        check_val("retedge_intr", aIntr, 0);
        tick();
        check_val("retedge_intr2", aIntr, 1);
        sb_pop_check("retedge", aId, aDataOut);
        a_ack();

        // Reset in SERVICE with a request line held high
        aReq[2] = 1'b1;
        Reset = 1'b1;
        tick();
        check_val("midrst_intr", aIntr, 0);
        check_val("midrst_id", aId, 0);
        check_val("midrst_data", aDataOut, 0);
        check_val("midrst_active", aActive, 0);
        Reset = 1'b0;
        a_mask(4'b0100);
        tick();
        tick();
        tick();
        check_val("postrst_intr", aIntr, 0);
        aReq[2] = 1'b0;
        tick();
        check_val("postrst_intr2", aIntr, 0);

        // Wide instance: top channel with a 32-bit vector
        bWrite = 1'b1; bSel = 3'd7; bDataIn = 32'hDEAD_BEEF;
        tick();
        bWrite = 1'b0;
        bMaskWrite = 1'b1; bDataIn = 32'h0000_0080;
        tick();
        bMaskWrite = 1'b0;
        bAck = 1'b1;
        tick();
        bAck = 1'b0;
        check_val("b_idle_ack_active", bActive, 0);
        check_val("b_idle_ack_intr", bIntr, 0);
        sb_push(7, 32'hDEAD_BEEF);
        bReq = 8'h88;
        tick();
        bReq = '0;
        wait_intr(1, "b_ch7");
        sb_pop_check("b_ch7", bId, bDataOut);
        bAck = 1'b1;
        tick();
        bAck = 1'b0;
        check_val("b_svc_active", bActive, 1);
        check_val("b_svc_data", bDataOut, 32'hDEAD_BEEF);

        check_val("sb_drain", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
`default_nettype wire
